// File: rtl/hilo_muldiv_ctrl_pkg.sv
// muldiv_pkg: op and state encodings plus the default datapath width shared by the HI/LO mul/div sequencer.
package muldiv_pkg;
   localparam int WIDTH_DEF = 32;
   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_FIX   = 2'b10;
endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// hilo_muldiv_ctrl_if: pipeline <-> HI/LO sequencer request/result bundle.
interface hilo_muldiv_ctrl_if import muldiv_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             mf_req;
   logic             wr_hi;
   logic             wr_lo;
   logic [WIDTH-1:0] wd;
   logic             flush;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             busy;
   logic             stall;
   logic             done;
   logic             div0;
   modport master (
      output start, op, a, b, mf_req, wr_hi, wr_lo, wd, flush,
      input  hi_q, lo_q, busy, stall, done, div0
   );
   modport slave (
      input  start, op, a, b, mf_req, wr_hi, wr_lo, wd, flush,
      output hi_q, lo_q, busy, stall, done, div0
   );
endinterface

// File: rtl/hilo_muldiv_ctrl_step.sv
// muldiv_step: one combinational iteration, shift-add multiply or restoring shift-subtract divide on the 2*WIDTH accumulator.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   d,
   output logic [2*WIDTH-1:0] acc_nxt
);
   logic [WIDTH:0] sum;
   logic [WIDTH:0] r;
   logic [WIDTH:0] diff;
   always_comb begin
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, d} : '0);
      r       = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff    = r - {1'b0, d};
      // remainder stays below the divisor, so a non-borrowing difference fits in WIDTH bits
      acc_nxt = !is_div ? {sum, acc[WIDTH-1:1]}
              : diff[WIDTH] ? {r[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
              : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO with pipeline stall.
// Define MULDIV_EARLY_OUT_EN to end multiplies once the remaining multiplier bits are zero.
module hilo_muldiv_ctrl import muldiv_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 6
) (
   input logic               clk,
   input logic               rst,
   hilo_muldiv_ctrl_if.slave bus
);
   localparam int W2 = 2 * WIDTH;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W2-1:0]    acc_q, acc_d, acc_nxt, res, fix_val;
   logic [WIDTH-1:0] dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
   logic             div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, div0_q, div0_d;
   logic             is_div, is_sgn, a_sgn, b_sgn, skip, last, busy, done;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div (div_q),
      .acc    (acc_q),
      .d      (dvs_q),
      .acc_nxt(acc_nxt)
   );

   always_comb begin
      is_div  = bus.op == OP_DIVU || bus.op == OP_DIV;
      is_sgn  = bus.op == OP_MULT || bus.op == OP_DIV;
      a_sgn   = is_sgn & bus.a[WIDTH-1];
      b_sgn   = is_sgn & bus.b[WIDTH-1];
      a_mag   = a_sgn ? -bus.a : bus.a;
      b_mag   = b_sgn ? -bus.b : bus.b;
      busy    = state_q != ST_IDLE;
      done    = state_q == ST_FIX && !bus.flush;
`ifdef MULDIV_EARLY_OUT_EN
      // cnt_q keeps the unconsumed step count, which is exactly the realignment shift
      skip    = b_mag == '0;
      last    = cnt_q == CNT_W'(1) || (!div_q &&
                (acc_nxt[WIDTH-1:0] & ~({WIDTH{1'b1}} << (cnt_q - 1'b1))) == '0);
      res     = acc_q >> cnt_q;
`else
      skip    = is_div && bus.b == '0;
      last    = cnt_q == CNT_W'(1);
      res     = acc_q;
`endif
      q_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      r_fix   = rneg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
      fix_val = div0_q ? acc_q : div_q ? {r_fix, q_fix} : neg_q ? -res : res;
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      dvs_d   = dvs_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      div0_d  = div0_q;
      if (state_q == ST_IDLE && bus.start) begin
         state_d = skip ? ST_FIX : ST_RUN;
         cnt_d   = CNT_INIT;
         div_d   = is_div;
         neg_d   = a_sgn ^ b_sgn;
         rneg_d  = a_sgn;
         div0_d  = is_div && bus.b == '0;
         dvs_d   = is_div ? b_mag : a_mag;
         acc_d   = div0_d ? {bus.a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
      end else if (state_q == ST_IDLE) begin
         hi_d = bus.wr_hi ? bus.wd : hi_q;
         lo_d = bus.wr_lo ? bus.wd : lo_q;
      end else if (state_q == ST_RUN) begin
         acc_d   = acc_nxt;
         cnt_d   = cnt_q - 1'b1;
         state_d = last ? ST_FIX : ST_RUN;
      end else begin
         {hi_d, lo_d} = fix_val;
         state_d      = ST_IDLE;
      end
      if (busy && bus.flush) begin
         state_d = ST_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         dvs_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         dvs_q   <= dvs_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         div0_q  <= div0_d;
      end
   end

   assign bus.hi_q  = hi_q;
   assign bus.lo_q  = lo_q;
   assign bus.busy  = busy;
   assign bus.stall = busy & (bus.start | bus.mf_req | bus.wr_hi | bus.wr_lo);
   assign bus.done  = done;
   assign bus.div0  = done & div0_q;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: scoreboard bench for the HI/LO mul/div sequencer against a 64-bit arithmetic reference.
module tb_hilo_muldiv_ctrl;
   import muldiv_pkg::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        d0;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0;
   int checks = 0;
   int passes = 0;
   exp_t sb[$];
   logic [31:0] mhi = '0;
   logic [31:0] mlo = '0;

   hilo_muldiv_ctrl_if #(.WIDTH(32)) bus();
   hilo_muldiv_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
   endtask

   task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output logic d0, output int lat);
      longint sa, sbv;
      logic [63:0] p;
      logic [31:0] bm;
      sa  = op[0] ? longint'($signed(a)) : longint'(a);
      sbv = op[0] ? longint'($signed(b)) : longint'(b);
      bm  = (op[0] && b[31]) ? -b : b;
      lat = 34;
      d0  = 1'b0;
      if (!op[1]) begin
         p = sa * sbv;
         h = p[63:32];
         l = p[31:0];
`ifdef MULDIV_EARLY_OUT_EN
         lat = 2;
         for (int i = 0; i < 32; i++) if (bm[i]) lat = i + 3;
`endif
      end else if (b == 0) begin
         h = a; l = '1; d0 = 1'b1; lat = 2;
      end else begin
         p = sa % sbv; h = p[31:0];
         p = sa / sbv; l = p[31:0];
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int c0, output int lat);
      exp_t e;
      logic [31:0] h, l;
      logic d0;
      model(op, a, b, h, l, d0, lat);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      c0 = cyc + 1;
      e.hi = h; e.lo = l; e.d0 = d0; e.cyc = c0 + lat - 2;
      sb.push_back(e);
      mhi = h; mlo = l;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input string n);
      int i;
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.busy) break;
      end
      chk({n, "_timeout"}, 64'(i < 200), 1);
   endtask

   task automatic run(input string n, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int c0, lat;
      issue(op, a, b, c0, lat);
      wait_idle(n);
   endtask

   // monitor: every done pulse must match the oldest expected result
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.div0) chk("div0_with_done", bus.done, 1);
         if (bus.done) begin
            if (sb.size() == 0) chk("spurious_done", bus.done, 0);
            else begin
               e = sb.pop_front();
               chk("done_cycle", cyc, e.cyc);
               chk("div0", bus.div0, e.d0);
               @(posedge clk); #1;
               chk("hi", bus.hi_q, e.hi);
               chk("lo", bus.lo_q, e.lo);
               chk("busy_after", bus.busy, 0);
            end
         end
      end
   end

   initial begin
      int c0, lat;
      logic [31:0] ph, pl, ra, rb;
      logic [1:0] rop;
      bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.mf_req = 1;
      bus.wr_hi = 0; bus.wr_lo = 0; bus.wd = 0; bus.flush = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_hi", bus.hi_q, 0);
      chk("rst_lo", bus.lo_q, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_stall", bus.stall, 0);
      chk("rst_done", bus.done, 0);
      bus.mf_req = 0;

      run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run("mult_neg", OP_MULT, 32'hFFFF_FFF9, 32'd3);
      run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
      run("divu_zero", OP_DIVU, 32'd100, 32'd0);
      run("div_zero_neg", OP_DIV, 32'h8000_0005, 32'd0);
      run("div_wrap", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000);

      // dependent MFHI/MFLO stalls through the whole operation including FIX
      issue(OP_MULTU, 32'd6, 32'd7, c0, lat);
      bus.mf_req = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         chk("stall_mf", bus.stall, 64'(cyc <= c0 + lat - 2));
         if (cyc > c0 + lat - 2) break;
      end
      bus.mf_req = 1'b0;
      chk("mfhi", bus.hi_q, 0);
      chk("mflo", bus.lo_q, 42);

      // idle MTHI/MTLO writes
      @(posedge clk); #1 bus.wr_hi = 1'b1; bus.wd = 32'h1234;
      @(posedge clk); #1 bus.wr_hi = 1'b0; mhi = 32'h1234;
      chk("mthi_hi", bus.hi_q, mhi);
      chk("mthi_lo", bus.lo_q, mlo);
      bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wd = 32'hA5A5_0F0F;
      @(posedge clk); #1 bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; mhi = 32'hA5A5_0F0F; mlo = 32'hA5A5_0F0F;
      chk("mtboth_hi", bus.hi_q, mhi);
      chk("mtboth_lo", bus.lo_q, mlo);

      // requests while busy stall and are not consumed
      pl = mlo;
      issue(OP_DIVU, 32'd1000, 32'd7, c0, lat);
      bus.wr_lo = 1'b1; bus.wd = 32'hBEEF;
      @(negedge clk);
      chk("stall_wr_lo", bus.stall, 1);
      @(posedge clk); #1 bus.wr_lo = 1'b0; bus.start = 1'b1; bus.op = OP_MULTU;
      chk("lo_busy_hold", bus.lo_q, pl);
      @(negedge clk);
      chk("stall_start", bus.stall, 1);
      @(posedge clk); #1 bus.start = 1'b0;
      wait_idle("busy_reqs");

      // flush mid-RUN keeps HI/LO
      ph = mhi; pl = mlo;
      @(posedge clk); #1 bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd5000; bus.b = 32'd3;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(posedge clk); #1 bus.flush = 1'b0;
      chk("flush_busy", bus.busy, 0);
      chk("flush_hi", bus.hi_q, ph);
      chk("flush_lo", bus.lo_q, pl);

      // flush beats completion in FIX
      @(posedge clk); #1 bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd9; bus.b = 32'd0;
      @(posedge clk); #1 bus.start = 1'b0; bus.flush = 1'b1;
      @(negedge clk);
      chk("flush_fix_done", bus.done, 0);
      @(posedge clk); #1 bus.flush = 1'b0;
      chk("flush_fix_busy", bus.busy, 0);
      chk("flush_fix_hi", bus.hi_q, ph);
      chk("flush_fix_lo", bus.lo_q, pl);

      // start with MT writes: writes dropped, then op flushed
      @(posedge clk); #1 bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd11; bus.b = 32'd13;
      bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wd = 32'hDEAD;
      @(posedge clk); #1 bus.start = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.flush = 1'b1;
      @(posedge clk); #1 bus.flush = 1'b0;
      chk("start_wr_hi", bus.hi_q, ph);
      chk("start_wr_lo", bus.lo_q, pl);

      // reset mid-RUN clears HI/LO
      @(posedge clk); #1 bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'hFFFF_0000; bus.b = 32'd5;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0; mhi = '0; mlo = '0;
      chk("rst_run_hi", bus.hi_q, mhi);
      chk("rst_run_lo", bus.lo_q, mlo);
      chk("rst_run_busy", bus.busy, 0);

      for (int i = 0; i < 25; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom();
         rb  = $urandom();
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 255));
            2: ra = 32'h8000_0000;
            3: rb = 32'hFFFF_FFFF;
            default: ;
         endcase
         run("rand", rop, ra, rb);
      end

      repeat (3) @(posedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
